// File: rtl/acc_pkg.sv
// Shared definitions for the channel accumulator sequencer: state encoding and default widths.
package acc_pkg;

  localparam int CW_DEFAULT = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_OUT   = 2'd2
  } state_e;

endpackage

// File: rtl/chnl_acc_sched.sv
// Sequences partial-sum beats into per-pixel accumulations of CIN_TILES beats each,
// hands finished pixels downstream with valid/ready, and pulses done after the last pixel.
module chnl_acc_sched
  import acc_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] cfg_tiles_m1,
  input  logic [CW-1:0] cfg_npix_m1,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          acc_en,
  output logic          acc_ld,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [CW-1:0] pix_idx,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [CW-1:0] tile_cnt_q, tile_cnt_d;
  logic [CW-1:0] pix_idx_q, pix_idx_d;
  logic [CW-1:0] tiles_m1_q, tiles_m1_d;
  logic [CW-1:0] npix_m1_q, npix_m1_d;
  logic          done_q, done_d;

  logic          is_last_pix;
  logic          is_last_tile;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tile_cnt_q <= '0;
      pix_idx_q  <= '0;
      tiles_m1_q <= '0;
      npix_m1_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tile_cnt_q <= tile_cnt_d;
      pix_idx_q  <= pix_idx_d;
      tiles_m1_q <= tiles_m1_d;
      npix_m1_q  <= npix_m1_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tile_cnt_d = tile_cnt_q;
    pix_idx_d  = pix_idx_q;
    tiles_m1_d = tiles_m1_q;
    npix_m1_d  = npix_m1_q;
    done_d     = 1'b0;

    is_last_pix  = (pix_idx_q == npix_m1_q);
    is_last_tile = (tile_cnt_q == tiles_m1_q);

    // In OUT a beat may only enter on the handshake cycle, so the held result is never disturbed.
    in_ready = (state_q == S_ACCUM) ||
               ((state_q == S_OUT) && out_ready && !is_last_pix);
    acc_en   = in_valid && in_ready;
    acc_ld   = acc_en && (tile_cnt_q == '0);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          tiles_m1_d = cfg_tiles_m1;
          npix_m1_d  = cfg_npix_m1;
          tile_cnt_d = '0;
          pix_idx_d  = '0;
          state_d    = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (acc_en) begin
          if (is_last_tile) begin
            tile_cnt_d = '0;
            state_d    = S_OUT;
          end else begin
            tile_cnt_d = tile_cnt_q + CW'(1);
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (is_last_pix) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            pix_idx_d = pix_idx_q + CW'(1);
            // An overlapped beat is tile 0 of the next pixel; with one tile it completes it.
            if (acc_en) begin
              if (tiles_m1_q == '0) begin
                tile_cnt_d = '0;
                state_d    = S_OUT;
              end else begin
                tile_cnt_d = CW'(1);
                state_d    = S_ACCUM;
              end
            end else begin
              state_d = S_ACCUM;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out_valid = (state_q == S_OUT);
  assign out_last  = out_valid && is_last_pix;
  assign pix_idx   = pix_idx_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_chnl_acc_sched.sv
// Self-checking bench for chnl_acc_sched: directed vector table, hand sequences and a
// randomized run checked against a beat-counting reference model with an accumulator scoreboard.
module tb_chnl_acc_sched;

  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] cfg_tiles_m1;
  logic [CW-1:0] cfg_npix_m1;
  logic          in_valid;
  logic          in_ready;
  logic          acc_en;
  logic          acc_ld;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [CW-1:0] pix_idx;
  logic          busy;
  logic          done;

  chnl_acc_sched #(.CW(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_tiles_m1 (cfg_tiles_m1),
    .cfg_npix_m1  (cfg_npix_m1),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .acc_en       (acc_en),
    .acc_ld       (acc_ld),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .pix_idx      (pix_idx),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a layer is a count of pixels, each pixel a count of accepted beats.
  bit          m_active;
  bit          m_present;
  bit          m_done;
  int          m_beats;
  int          m_tiles;
  int          m_pix;
  int          m_npix;
  int unsigned m_sum;
  int unsigned m_pres_sum;

  // Bench-side accumulator driven by the DUT's load/enable strobes.
  int unsigned acc;

  // Values observed on the most recent cycle, for table comparisons and counting.
  logic obs_ir, obs_en, obs_ld, obs_ov, obs_last, obs_busy, obs_done;
  int   hs_cnt;

  typedef struct {
    logic st, iv, orr;
    logic ir, en, ld, ov, last, bsy, dn;
  } vec_t;

  vec_t tbl[7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active  = 0;
    m_present = 0;
    m_done    = 0;
    m_beats   = 0;
    m_pix     = 0;
  endtask

  // Drive one cycle (entered at posedge+1), check mid-cycle, advance the model at the edge.
  task automatic applyStimulus(input logic st, input logic iv, input logic orr, input int unsigned din);
    bit exp_last, exp_ir, exp_en, exp_ld, hs;
    start     = st;
    in_valid  = iv;
    out_ready = orr;
    #3;
    exp_last = m_present && (m_pix == m_npix - 1);
    exp_ir   = m_active && (!m_present || (orr && !exp_last));
    exp_en   = exp_ir && iv;
    exp_ld   = exp_en && (m_beats == 0);
    checkOutput("in_ready", in_ready, exp_ir);
    checkOutput("acc_en", acc_en, exp_en);
    checkOutput("acc_ld", acc_ld, exp_ld);
    checkOutput("out_valid", out_valid, m_present);
    checkOutput("out_last", out_last, exp_last);
    checkOutput("busy", busy, m_active);
    checkOutput("done", done, m_done);
    if (m_active) checkOutput("pix_idx", pix_idx, m_pix);
    if (m_present) checkOutput("acc_sum", acc, m_pres_sum);
    obs_ir = in_ready; obs_en = acc_en; obs_ld = acc_ld; obs_ov = out_valid;
    obs_last = out_last; obs_busy = busy; obs_done = done;
    if (out_valid && orr) hs_cnt++;
    @(posedge clk);
    if (obs_en) acc = obs_ld ? din : acc + din;
    hs = m_present && orr;
    if (!m_active) begin
      if (st) begin
        m_active  = 1;
        m_present = 0;
        m_tiles   = int'(cfg_tiles_m1) + 1;
        m_npix    = int'(cfg_npix_m1) + 1;
        m_pix     = 0;
        m_beats   = 0;
      end
    end else begin
      if (hs) begin
        if (exp_last) m_active = 0;
        else m_pix++;
        m_present = 0;
      end
      if (exp_en) begin
        m_sum = (m_beats == 0) ? din : m_sum + din;
        m_beats++;
        if (m_beats == m_tiles) begin
          m_beats    = 0;
          m_present  = 1;
          m_pres_sum = m_sum;
        end
      end
    end
    m_done = hs && exp_last;
    #1;
  endtask

  // Keep feeding stimulus until the model's layer completes, within a cycle budget.
  task automatic finish_layer(input int pct_valid, input int pct_ready, input int budget);
    int n = 0;
    while (m_active && n < budget) begin
      applyStimulus(1'b0, ($urandom_range(99) < pct_valid), ($urandom_range(99) < pct_ready),
                    $urandom_range(255));
      n++;
    end
    if (m_active) checkOutput("layer_timeout", 1, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_tiles_m1 = '0; cfg_npix_m1 = '0; acc = 0; hs_cnt = 0;
    model_reset();

    // Reset state
    #2;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pix_idx", pix_idx, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Test 1: three tiles, one pixel, in_valid held high
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    cfg_tiles_m1 = 16'd2; cfg_npix_m1 = 16'd0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(tbl[i].st, tbl[i].iv, tbl[i].orr, $urandom_range(255));
      checkOutput($sformatf("t1_ir[%0d]", i), obs_ir, tbl[i].ir);
      checkOutput($sformatf("t1_en[%0d]", i), obs_en, tbl[i].en);
      checkOutput($sformatf("t1_ld[%0d]", i), obs_ld, tbl[i].ld);
      checkOutput($sformatf("t1_ov[%0d]", i), obs_ov, tbl[i].ov);
      checkOutput($sformatf("t1_last[%0d]", i), obs_last, tbl[i].last);
      checkOutput($sformatf("t1_busy[%0d]", i), obs_busy, tbl[i].bsy);
      checkOutput($sformatf("t1_done[%0d]", i), obs_done, tbl[i].dn);
    end

    // Test 2: single tile, four pixels, full throughput
    cfg_tiles_m1 = 16'd0; cfg_npix_m1 = 16'd3; hs_cnt = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, $urandom_range(255));
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 1'b1, $urandom_range(255));
    checkOutput("t2_handshakes", hs_cnt, 4);

    // Test 3: backpressure for five cycles while presenting the first pixel
    cfg_tiles_m1 = 16'd1; cfg_npix_m1 = 16'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16);
    applyStimulus(1'b0, 1'b1, 1'b0, 7);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 99);
      checkOutput("t3_hold_ov", obs_ov, 1);
      checkOutput("t3_hold_en", obs_en, 0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 3);
    checkOutput("t3_pix_after", pix_idx, 1);
    finish_layer(100, 100, 20);

    // Test 4: random bubbles and backpressure over several layers
    for (int l = 0; l < 8; l++) begin
      cfg_tiles_m1 = CW'($urandom_range(3));
      cfg_npix_m1  = CW'($urandom_range(4));
      applyStimulus(1'b1, 1'b0, 1'b0, 0);
      finish_layer(30, 60, 400);
    end

    // Test 5: start with new cfg while busy is ignored
    cfg_tiles_m1 = 16'd1; cfg_npix_m1 = 16'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 5);
    cfg_tiles_m1 = 16'd5; cfg_npix_m1 = 16'd5;
    applyStimulus(1'b1, 1'b1, 1'b0, 6);
    checkOutput("t5_out_after_2", out_valid, 1);
    finish_layer(100, 100, 30);

    // Test 6: asynchronous reset in the middle of a pixel
    cfg_tiles_m1 = 16'd2; cfg_npix_m1 = 16'd0;
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 11);
    in_valid = 1'b1; out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_in_ready", in_ready, 0);
    checkOutput("t6_acc_en", acc_en, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_out_valid", out_valid, 0);
    checkOutput("t6_pix_idx", pix_idx, 0);
    model_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 40);
    checkOutput("t6_first_ld", obs_ld, 1);
    finish_layer(100, 100, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
